// File: rtl/balanca_pkg.sv
// rtl/balanca_pkg.sv - shared constants, widths and FSM states for the scale conversion blocks
package balanca_pkg;

    localparam int KG_SCALE  = 1000;
    localparam int FRAC_MAX  = 999;
    localparam int GRAMS_MAX = 4095;

    localparam int INT_W   = 12;
    localparam int FRAC_W  = 10;
    localparam int GRAMS_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2
    } state_e;

endpackage

// File: rtl/kilograms_to_grams.sv
// rtl/kilograms_to_grams.sv - sequential kilogram (int + thousandths) to gram converter
module kilograms_to_grams #(
    parameter int INT_W   = balanca_pkg::INT_W,
    parameter int FRAC_W  = balanca_pkg::FRAC_W,
    parameter int GRAMS_W = balanca_pkg::GRAMS_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [INT_W-1:0]   weightInKilogramsInteger,
    input  logic [FRAC_W-1:0]  weightInKilogramsFraction,
    output logic               busy,
    output logic               done,
    output logic [GRAMS_W-1:0] weightInGrams,
    output logic               overflow,
    output logic               invalid
);

    // Accumulator is wide enough that max_int * 1000 + fraction never wraps.
    localparam int ACC_W = INT_W + FRAC_W;

    // Multiplier constant walked LSB first, one bit per MUL cycle.
    localparam logic [9:0]         SCALE_BITS = 10'(balanca_pkg::KG_SCALE);
    localparam logic [3:0]         LAST_BIT   = 4'd9;
    localparam logic [FRAC_W-1:0]  FRAC_LIMIT = FRAC_W'(balanca_pkg::FRAC_MAX);
    localparam logic [ACC_W-1:0]   SUM_LIMIT  = ACC_W'(balanca_pkg::GRAMS_MAX);
    localparam logic [GRAMS_W-1:0] GRAMS_SAT  = GRAMS_W'(balanca_pkg::GRAMS_MAX);

    balanca_pkg::state_e state;

    logic [ACC_W-1:0]  multiplicand;
    logic [ACC_W-1:0]  accumulator;
    logic [FRAC_W-1:0] fraction;
    logic [3:0]        bit_index;
    logic [ACC_W-1:0]  sum;

    // Fraction add feeding the range check in ADD.
    always_comb begin
        sum = accumulator + {{INT_W{1'b0}}, fraction};
    end

    // Busy covers every non-idle cycle: 10 MUL cycles plus the ADD cycle.
    always_comb begin
        busy = (state != balanca_pkg::IDLE);
    end

    // Control FSM and shift-add datapath; reset takes priority over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= balanca_pkg::IDLE;
            multiplicand  <= '0;
            accumulator   <= '0;
            fraction      <= '0;
            bit_index     <= '0;
            done          <= 1'b0;
            weightInGrams <= '0;
            overflow      <= 1'b0;
            invalid       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                balanca_pkg::IDLE: begin
                    if (start) begin
                        multiplicand <= {{FRAC_W{1'b0}}, weightInKilogramsInteger};
                        fraction     <= weightInKilogramsFraction;
                        accumulator  <= '0;
                        bit_index    <= '0;
                        overflow     <= 1'b0;
                        invalid      <= 1'b0;
                        state        <= balanca_pkg::MUL;
                    end
                end
                balanca_pkg::MUL: begin
                    if (SCALE_BITS[bit_index]) begin
                        accumulator <= accumulator + (multiplicand << bit_index);
                    end
                    if (bit_index == LAST_BIT) begin
                        state <= balanca_pkg::ADD;
                    end else begin
                        bit_index <= bit_index + 4'd1;
                    end
                end
                balanca_pkg::ADD: begin
                    if (fraction > FRAC_LIMIT) begin
                        invalid       <= 1'b1;
                        overflow      <= 1'b0;
                        weightInGrams <= '0;
                    end else if (sum > SUM_LIMIT) begin
                        invalid       <= 1'b0;
                        overflow      <= 1'b1;
                        weightInGrams <= GRAMS_SAT;
                    end else begin
                        invalid       <= 1'b0;
                        overflow      <= 1'b0;
                        weightInGrams <= sum[GRAMS_W-1:0];
                    end
                    done  <= 1'b1;
                    state <= balanca_pkg::IDLE;
                end
                default: begin
                    state <= balanca_pkg::IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kilograms_to_grams.sv
// tb/tb_kilograms_to_grams.sv - directed self-checking bench for kilograms_to_grams
module tb_kilograms_to_grams;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] kg_int;
    logic [9:0]  kg_frac;
    logic        busy;
    logic        done;
    logic [11:0] grams;
    logic        overflow;
    logic        invalid;

    int pass_cnt = 0;
    int total    = 0;

    kilograms_to_grams dut (
        .clk                       (clk),
        .rst                       (rst),
        .start                     (start),
        .weightInKilogramsInteger  (kg_int),
        .weightInKilogramsFraction (kg_frac),
        .busy                      (busy),
        .done                      (done),
        .weightInGrams             (grams),
        .overflow                  (overflow),
        .invalid                   (invalid)
    );

    always #5 clk = ~clk;

    // Starts a conversion from the current negedge and waits for done.
    // lat is the capture-to-result edge count, busy_cnt the busy cycles seen.
    task automatic run_conv(input logic [11:0] i_val, input logic [9:0] f_val,
                            output int lat, output int busy_cnt, output logic timeout);
        int cyc;
        start    = 1'b1;
        kg_int   = i_val;
        kg_frac  = f_val;
        busy_cnt = 0;
        lat      = -1;
        timeout  = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        kg_int  = 12'hABC;
        kg_frac = 10'h155;
        for (cyc = 1; cyc <= 40; cyc++) begin
            if (busy) busy_cnt++;
            if (done) begin
                lat     = cyc - 1;
                timeout = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        kg_int  = 12'd7;
        kg_frac = 10'd7;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
        total++; if (grams !== 12'd0) $display("FAIL reset_grams got %0d want 0", grams); else pass_cnt++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else pass_cnt++;
        total++; if (invalid !== 1'b0) $display("FAIL reset_invalid got %b want 0", invalid); else pass_cnt++;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, bc;
        logic to;
        run_conv(12'd1, 10'd500, lat, bc, to);
        total++; if (to) $display("FAIL basic_timeout got no done want done"); else pass_cnt++;
        total++; if (lat != 11) $display("FAIL basic_latency got %0d want 11", lat); else pass_cnt++;
        total++; if (bc != 11) $display("FAIL basic_busy_cycles got %0d want 11", bc); else pass_cnt++;
        total++; if (grams !== 12'd1500) $display("FAIL basic_grams got %0d want 1500", grams); else pass_cnt++;
        total++; if (overflow !== 1'b0 || invalid !== 1'b0)
            $display("FAIL basic_flags got ov=%b inv=%b want 0 0", overflow, invalid); else pass_cnt++;
        @(negedge clk);
        total++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done); else pass_cnt++;
        total++; if (grams !== 12'd1500) $display("FAIL basic_grams_hold got %0d want 1500", grams); else pass_cnt++;
    endtask

    task automatic test_overflow();
        int lat, bc;
        logic to;
        run_conv(12'd4, 10'd95, lat, bc, to);
        total++; if (to || grams !== 12'd4095 || overflow !== 1'b0)
            $display("FAIL ovf_edge got to=%b g=%0d ov=%b want 0 4095 0", to, grams, overflow); else pass_cnt++;
        run_conv(12'd4, 10'd96, lat, bc, to);
        total++; if (to || grams !== 12'd4095 || overflow !== 1'b1)
            $display("FAIL ovf_over got to=%b g=%0d ov=%b want 0 4095 1", to, grams, overflow); else pass_cnt++;
        run_conv(12'd4095, 10'd999, lat, bc, to);
        total++; if (to || grams !== 12'd4095 || overflow !== 1'b1 || invalid !== 1'b0)
            $display("FAIL ovf_max got to=%b g=%0d ov=%b inv=%b want 0 4095 1 0", to, grams, overflow, invalid); else pass_cnt++;
    endtask

    task automatic test_invalid();
        int lat, bc;
        logic to;
        run_conv(12'd0, 10'd1000, lat, bc, to);
        total++; if (to || grams !== 12'd0 || invalid !== 1'b1 || overflow !== 1'b0)
            $display("FAIL invalid_frac got to=%b g=%0d inv=%b ov=%b want 0 0 1 0", to, grams, invalid, overflow); else pass_cnt++;
        run_conv(12'd0, 10'd0, lat, bc, to);
        total++; if (to || grams !== 12'd0 || invalid !== 1'b0 || overflow !== 1'b0)
            $display("FAIL zero_input got to=%b g=%0d inv=%b ov=%b want 0 0 0 0", to, grams, invalid, overflow); else pass_cnt++;
    endtask

    task automatic test_ignore_start();
        int cyc, lat;
        logic to;
        start   = 1'b1;
        kg_int  = 12'd2;
        kg_frac = 10'd0;
        lat = -1;
        to  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 1; cyc <= 40; cyc++) begin
            if (done) begin
                lat = cyc - 1;
                to  = 1'b0;
                break;
            end
            if (cyc == 5) begin
                start   = 1'b1;
                kg_int  = 12'd9;
                kg_frac = 10'd123;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        total++; if (to || lat != 11) $display("FAIL ignore_latency got to=%b lat=%0d want 0 11", to, lat); else pass_cnt++;
        total++; if (grams !== 12'd2000) $display("FAIL ignore_grams got %0d want 2000", grams); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic to;
        // Called on the done cycle of the previous conversion.
        run_conv(12'd3, 10'd7, lat, bc, to);
        total++; if (to || lat != 11) $display("FAIL b2b_latency got to=%b lat=%0d want 0 11", to, lat); else pass_cnt++;
        total++; if (grams !== 12'd3007) $display("FAIL b2b_grams got %0d want 3007", grams); else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int lat, bc;
        logic to;
        logic seen_done;
        start   = 1'b1;
        kg_int  = 12'd5;
        kg_frac = 10'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0 || grams !== 12'd0 || overflow !== 1'b0 || invalid !== 1'b0)
            $display("FAIL midrst_state got b=%b d=%b g=%0d ov=%b inv=%b want 0 0 0 0 0",
                     busy, done, grams, overflow, invalid); else pass_cnt++;
        seen_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        total++; if (seen_done) $display("FAIL midrst_no_done got done pulse want none"); else pass_cnt++;
        run_conv(12'd1, 10'd1, lat, bc, to);
        total++; if (to || lat != 11 || grams !== 12'd1001)
            $display("FAIL midrst_after got to=%b lat=%0d g=%0d want 0 11 1001", to, lat, grams); else pass_cnt++;
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        kg_int  = '0;
        kg_frac = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_overflow();
        test_invalid();
        @(negedge clk);
        test_ignore_start();
        test_back_to_back();
        @(negedge clk);
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
